mcode_seq: RTL and testbench



---
 rtl/k6502_defs.sv | 92 +++++++++
 rtl/mcode_rom.sv | 71 +++++++
 rtl/mcode_seq.sv | 183 ++++++++++++++++++
 tb/tb_mcode_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/k6502_defs.sv
// k6502_defs: shared definitions for the k6502 microcode sequencer.
// Holds the control-word field layout, register-select and address-mode
// codes, the one-hot cycle constants, opcode constants and a helper that
// packs a control word from its fields.
package k6502_defs;

    // Control word width and field bit positions
    localparam int X_BITS      = 11;
    localparam int XB_NEXT     = 0;   // end of instruction, fetch next opcode
    localparam int XB_INC_PC   = 1;   // increment program counter
    localparam int XB_INC_DL   = 2;   // increment data latch (pointer walk)
    localparam int XB_DL_PC    = 3;   // load PC from the data latch
    localparam int XB_AM_LO    = 4;   // address mode select, 2 bits
    localparam int XB_AM_HI    = 5;
    localparam int XB_RSEL_LO  = 6;   // register select, 3 bits
    localparam int XB_RSEL_HI  = 8;
    localparam int XB_REGR     = 9;   // register read onto data bus
    localparam int XB_REGW     = 10;  // register write from data bus

    // Register select codes
    typedef enum logic [2:0] {
        R_A   = 3'd0,
        R_X   = 3'd1,
        R_Y   = 3'd2,
        R_S   = 3'd3,
        R_P   = 3'd4,
        R_PCL = 3'd5,
        R_PCH = 3'd6,
        R_DL  = 3'd7
    } reg_sel_e;

    // Address bus source codes
    typedef enum logic [1:0] {
        ADDR_MODE_PC    = 2'd0,
        ADDR_MODE_DL    = 2'd1,
        ADDR_MODE_STACK = 2'd2,
        ADDR_MODE_VEC   = 2'd3
    } addr_mode_e;

    // Vector selection reported with an injected instruction
    typedef enum logic [1:0] {
        VEC_BRK = 2'b00,
        VEC_IRQ = 2'b01,
        VEC_NMI = 2'b10
    } vec_sel_e;

    // One-hot cycle constants for the default 6-step depth; C_N is all-zero
    localparam logic [5:0] C_N = 6'b000000;
    localparam logic [5:0] C_0 = 6'b000001;
    localparam logic [5:0] C_1 = 6'b000010;
    localparam logic [5:0] C_2 = 6'b000100;
    localparam logic [5:0] C_3 = 6'b001000;
    localparam logic [5:0] C_4 = 6'b010000;
    localparam logic [5:0] C_5 = 6'b100000;

    // Opcodes known to the table
    localparam logic [7:0] OP_BRK     = 8'h00;
    localparam logic [7:0] OP_KIL     = 8'h02;  // jams: never signals NEXT
    localparam logic [7:0] OP_JMP_IND = 8'h6C;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    // Pack a control word from its individual fields
    function automatic logic [X_BITS-1:0] mk_x(
        input logic       regw,
        input logic       regr,
        input reg_sel_e   rsel,
        input addr_mode_e am,
        input logic       dl_pc,
        input logic       inc_dl,
        input logic       inc_pc,
        input logic       next
    );
        logic [X_BITS-1:0] w;
        w                          = {X_BITS{1'b0}};
        w[XB_REGW]                 = regw;
        w[XB_REGR]                 = regr;
        w[XB_RSEL_HI:XB_RSEL_LO]   = rsel;
        w[XB_AM_HI:XB_AM_LO]       = am;
        w[XB_DL_PC]                = dl_pc;
        w[XB_INC_DL]               = inc_dl;
        w[XB_INC_PC]               = inc_pc;
        w[XB_NEXT]                 = next;
        return w;
    endfunction

    // Word for any (opcode, cycle) pair not in the table: forces a new fetch
    localparam logic [X_BITS-1:0] X_DEFAULT = 11'h001;
    // Word that never ends the instruction
    localparam logic [X_BITS-1:0] X_JAM     = 11'h000;

endpackage

// File: rtl/mcode_rom.sv
// mcode_rom: purely combinational microcode table.
// Ports:
//   ir    [7:0]        current opcode
//   cycle [CYCLES-1:0] one-hot micro-step (all-zero = C_N)
//   x     [XW-1:0]     control word for this (opcode, step)
// The table is written for a cycle depth of at least 6 steps.
module mcode_rom
    import k6502_defs::*;
#(
    parameter int CYCLES = 6,
    parameter int XW     = X_BITS
) (
    input  logic [7:0]        ir,
    input  logic [CYCLES-1:0] cycle,
    output logic [XW-1:0]     x
);

    localparam logic [CYCLES-1:0] S_N = CYCLES'(C_N);
    localparam logic [CYCLES-1:0] S_0 = CYCLES'(C_0);
    localparam logic [CYCLES-1:0] S_1 = CYCLES'(C_1);
    localparam logic [CYCLES-1:0] S_2 = CYCLES'(C_2);
    localparam logic [CYCLES-1:0] S_3 = CYCLES'(C_3);
    localparam logic [CYCLES-1:0] S_4 = CYCLES'(C_4);

    // Table lookup: opcode selects a column, the one-hot step selects the row
    always_comb begin
        x = X_DEFAULT;
        case (ir)
            OP_BRK: begin
                case (cycle)
                    // C_N is the post-reset / post-trap slot: vector fetch, then new opcode
                    S_N:     x = mk_x(1'b0, 1'b0, R_A,   ADDR_MODE_VEC,   1'b0, 1'b0, 1'b0, 1'b1);
                    S_0:     x = mk_x(1'b0, 1'b1, R_PCH, ADDR_MODE_STACK, 1'b0, 1'b0, 1'b0, 1'b0);
                    S_1:     x = mk_x(1'b0, 1'b1, R_PCL, ADDR_MODE_STACK, 1'b0, 1'b0, 1'b0, 1'b0);
                    S_2:     x = mk_x(1'b0, 1'b1, R_P,   ADDR_MODE_STACK, 1'b0, 1'b0, 1'b0, 1'b0);
                    S_3:     x = mk_x(1'b1, 1'b0, R_DL,  ADDR_MODE_VEC,   1'b0, 1'b0, 1'b0, 1'b0);
                    S_4:     x = mk_x(1'b0, 1'b0, R_A,   ADDR_MODE_VEC,   1'b1, 1'b0, 1'b0, 1'b1);
                    default: x = X_DEFAULT;
                endcase
            end
            OP_NOP: begin
                case (cycle)
                    S_0:     x = mk_x(1'b0, 1'b0, R_A, ADDR_MODE_PC, 1'b0, 1'b0, 1'b0, 1'b0);
                    S_1:     x = mk_x(1'b0, 1'b0, R_A, ADDR_MODE_PC, 1'b0, 1'b0, 1'b0, 1'b1);
                    default: x = X_DEFAULT;
                endcase
            end
            OP_LDA_IMM: begin
                case (cycle)
                    S_0:     x = mk_x(1'b0, 1'b0, R_A, ADDR_MODE_PC, 1'b0, 1'b0, 1'b1, 1'b0);
                    S_1:     x = mk_x(1'b1, 1'b0, R_A, ADDR_MODE_PC, 1'b0, 1'b0, 1'b0, 1'b1);
                    default: x = X_DEFAULT;
                endcase
            end
            OP_JMP_IND: begin
                case (cycle)
                    S_0:     x = mk_x(1'b1, 1'b0, R_DL, ADDR_MODE_PC, 1'b0, 1'b0, 1'b1, 1'b0);
                    S_1:     x = mk_x(1'b1, 1'b0, R_DL, ADDR_MODE_PC, 1'b0, 1'b0, 1'b1, 1'b0);
                    S_2:     x = mk_x(1'b1, 1'b0, R_DL, ADDR_MODE_DL, 1'b0, 1'b1, 1'b0, 1'b0);
                    S_3:     x = mk_x(1'b1, 1'b0, R_DL, ADDR_MODE_DL, 1'b0, 1'b0, 1'b0, 1'b0);
                    S_4:     x = mk_x(1'b0, 1'b0, R_A,  ADDR_MODE_PC, 1'b1, 1'b0, 1'b0, 1'b1);
                    default: x = X_DEFAULT;
                endcase
            end
            // Jam opcode: never ends, so the sequencer runs into the overrun trap
            OP_KIL:  x = X_JAM;
            default: x = X_DEFAULT;
        endcase
    end

endmodule

// File: rtl/mcode_seq.sv
// mcode_seq: microcode sequencer for the k6502 core.
// Owns the instruction register, one-hot cycle counter, RDY stall,
// NMI/IRQ injection at instruction boundaries and the overrun trap.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   rdy              1 = advance, 0 = freeze sequencer state
//   din   [7:0]      data bus, opcode source at boundaries
//   nmi_n            NMI request, falling-edge, asynchronous
//   irq_n            IRQ request, level, active-low, asynchronous
//   i_flag           interrupt-disable flag
//   x     [XW-1:0]   control word (table output, HOLD_MASK gated by rdy)
//   ir_q  [7:0]      instruction register
//   cycle_q          one-hot step, all-zero = C_N
//   sync             high in the opcode-fetch step C_0
//   inject           current instruction was injected
//   vec_sel [1:0]    00 BRK/reset, 01 IRQ, 10 NMI
//   trap             sticky cycle-overrun flag
module mcode_seq
    import k6502_defs::*;
#(
    parameter int               CYCLES    = 6,
    parameter int               XW        = X_BITS,
    parameter logic [XW-1:0]    HOLD_MASK = 11'b11000000000,
    parameter int               NEXT_BIT  = 0,
    parameter logic [7:0]       INJ_OP    = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rdy,
    input  logic [7:0]        din,
    input  logic              nmi_n,
    input  logic              irq_n,
    input  logic              i_flag,
    output logic [XW-1:0]     x,
    output logic [7:0]        ir_q,
    output logic [CYCLES-1:0] cycle_q,
    output logic              sync,
    output logic              inject,
    output logic [1:0]        vec_sel,
    output logic              trap
);

    localparam logic [CYCLES-1:0] CYC_N = {CYCLES{1'b0}};
    localparam logic [CYCLES-1:0] CYC_0 = {{(CYCLES-1){1'b0}}, 1'b1};

    logic [XW-1:0]     x_rom_s;
    logic              next_s;
    logic              last_s;
    logic              irq_req_s;
    logic              nmi_fall_s;
    logic              take_nmi_s;

    logic [7:0]        ir_nxt_s;
    logic [CYCLES-1:0] cycle_nxt_s;
    logic              inject_nxt_s;
    logic [1:0]        vec_nxt_s;
    logic              trap_nxt_s;

    logic              nmi_meta_r;
    logic              nmi_sync_r;
    logic              nmi_sync_d_r;
    logic              nmi_pend_r;
    logic              irq_meta_r;
    logic              irq_sync_r;

    mcode_rom #(
        .CYCLES (CYCLES),
        .XW     (XW)
    ) u_rom (
        .ir    (ir_q),
        .cycle (cycle_q),
        .x     (x_rom_s)
    );

    assign next_s     = x_rom_s[NEXT_BIT];
    assign last_s     = cycle_q[CYCLES-1];
    assign irq_req_s  = ~irq_sync_r & ~i_flag;
    assign nmi_fall_s = nmi_sync_d_r & ~nmi_sync_r;
    assign take_nmi_s = rdy & next_s & nmi_pend_r;

    // Control word: bus-write/read strobes are suppressed while stalled
    always_comb begin
        if (rdy) begin
            x = x_rom_s;
        end else begin
            x = x_rom_s & ~HOLD_MASK;
        end
    end

    // Next-state for the sequencer: boundary, normal step or overrun trap
    always_comb begin
        ir_nxt_s     = ir_q;
        cycle_nxt_s  = cycle_q;
        inject_nxt_s = inject;
        vec_nxt_s    = vec_sel;
        trap_nxt_s   = trap;
        if (rdy) begin
            if (next_s) begin
                cycle_nxt_s = CYC_0;
                if (nmi_pend_r) begin
                    ir_nxt_s     = INJ_OP;
                    inject_nxt_s = 1'b1;
                    vec_nxt_s    = VEC_NMI;
                end else if (irq_req_s) begin
                    ir_nxt_s     = INJ_OP;
                    inject_nxt_s = 1'b1;
                    vec_nxt_s    = VEC_IRQ;
                end else begin
                    ir_nxt_s     = din;
                    inject_nxt_s = 1'b0;
                    vec_nxt_s    = VEC_BRK;
                end
            end else if (last_s) begin
                // Ran past the last step without NEXT: re-run the reset sequence
                trap_nxt_s   = 1'b1;
                ir_nxt_s     = INJ_OP;
                cycle_nxt_s  = CYC_N;
                inject_nxt_s = 1'b1;
                vec_nxt_s    = VEC_BRK;
            end else if (cycle_q == CYC_N) begin
                cycle_nxt_s = CYC_0;
            end else begin
                cycle_nxt_s = {cycle_q[CYCLES-2:0], 1'b0};
            end
        end else begin
            ir_nxt_s     = ir_q;
            cycle_nxt_s  = cycle_q;
            inject_nxt_s = inject;
            vec_nxt_s    = vec_sel;
            trap_nxt_s   = trap;
        end
    end

    // Sequencer state and registered outputs; sync tracks the next cycle value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q    <= INJ_OP;
            cycle_q <= CYC_N;
            sync    <= 1'b0;
            inject  <= 1'b0;
            vec_sel <= VEC_BRK;
            trap    <= 1'b0;
        end else begin
            ir_q    <= ir_nxt_s;
            cycle_q <= cycle_nxt_s;
            sync    <= (cycle_nxt_s == CYC_0);
            inject  <= inject_nxt_s;
            vec_sel <= vec_nxt_s;
            trap    <= trap_nxt_s;
        end
    end

    // Interrupt input synchronisers; they run regardless of rdy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_meta_r   <= 1'b1;
            nmi_sync_r   <= 1'b1;
            nmi_sync_d_r <= 1'b1;
            irq_meta_r   <= 1'b1;
            irq_sync_r   <= 1'b1;
        end else begin
            nmi_meta_r   <= nmi_n;
            nmi_sync_r   <= nmi_meta_r;
            nmi_sync_d_r <= nmi_sync_r;
            irq_meta_r   <= irq_n;
            irq_sync_r   <= irq_meta_r;
        end
    end

    // NMI pending latch: a new falling edge wins over the clear on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_pend_r <= 1'b0;
        end else if (nmi_fall_s) begin
            nmi_pend_r <= 1'b1;
        end else if (take_nmi_s) begin
            nmi_pend_r <= 1'b0;
        end else begin
            nmi_pend_r <= nmi_pend_r;
        end
    end

endmodule

// File: tb/tb_mcode_seq.sv
// Self-checking bench for mcode_seq: a table of per-clock vectors for the
// main instruction flow, then hand-written sequences for NMI/IRQ priority,
// overrun trap and asynchronous reset mid-instruction.
module tb_mcode_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rdy = 1'b1;
    logic [7:0]  din = 8'hEA;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        i_flag = 1'b1;
    logic [10:0] x;
    logic [7:0]  ir_q;
    logic [5:0]  cycle_q;
    logic        sync;
    logic        inject;
    logic [1:0]  vec_sel;
    logic        trap;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rdy;
        logic [7:0]  din;
        logic        irq_n;
        logic        i_flag;
        logic [5:0]  cyc;
        logic [7:0]  ir;
        logic        inj;
        logic [1:0]  vec;
        logic        sy;
        logic        tr;
        logic [10:0] xe;
    } vec_t;

    vec_t rows [22];

    mcode_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rdy     (rdy),
        .din     (din),
        .nmi_n   (nmi_n),
        .irq_n   (irq_n),
        .i_flag  (i_flag),
        .x       (x),
        .ir_q    (ir_q),
        .cycle_q (cycle_q),
        .sync    (sync),
        .inject  (inject),
        .vec_sel (vec_sel),
        .trap    (trap)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [5:0] cyc, input logic [7:0] ir,
                             input logic inj, input logic [1:0] vec, input logic sy,
                             input logic tr, input logic [10:0] xe);
        chk({tag, " cycle_q"}, 32'(cycle_q), 32'(cyc));
        chk({tag, " ir_q"},    32'(ir_q),    32'(ir));
        chk({tag, " inject"},  32'(inject),  32'(inj));
        chk({tag, " vec_sel"}, 32'(vec_sel), 32'(vec));
        chk({tag, " sync"},    32'(sync),    32'(sy));
        chk({tag, " trap"},    32'(trap),    32'(tr));
        chk({tag, " x"},       32'(x),       32'(xe));
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rdy    = rows[i].rdy;
            din    = rows[i].din;
            irq_n  = rows[i].irq_n;
            i_flag = rows[i].i_flag;
            tick(1);
            chk_state($sformatf("row%0d", i), rows[i].cyc, rows[i].ir, rows[i].inj,
                      rows[i].vec, rows[i].sy, rows[i].tr, rows[i].xe);
        end
    endtask

    initial begin
        //           rdy   din    irq_n i_flag | cyc    ir     inj   vec    sy    tr    x
        rows[0]  = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd1,  8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000};
        rows[1]  = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd2,  8'hEA, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[2]  = '{1'b1, 8'hA9, 1'b1, 1'b1,  6'd1,  8'hA9, 1'b0, 2'b00, 1'b1, 1'b0, 11'h002};
        rows[3]  = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd2,  8'hA9, 1'b0, 2'b00, 1'b0, 1'b0, 11'h401};
        rows[4]  = '{1'b0, 8'hEA, 1'b1, 1'b1,  6'd2,  8'hA9, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[5]  = '{1'b0, 8'hEA, 1'b1, 1'b1,  6'd2,  8'hA9, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[6]  = '{1'b0, 8'hEA, 1'b1, 1'b1,  6'd2,  8'hA9, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[7]  = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd1,  8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000};
        rows[8]  = '{1'b1, 8'hEA, 1'b0, 1'b1,  6'd2,  8'hEA, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[9]  = '{1'b1, 8'hEA, 1'b0, 1'b1,  6'd1,  8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000};
        rows[10] = '{1'b1, 8'hEA, 1'b0, 1'b1,  6'd2,  8'hEA, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[11] = '{1'b1, 8'hA9, 1'b0, 1'b1,  6'd1,  8'hA9, 1'b0, 2'b00, 1'b1, 1'b0, 11'h002};
        rows[12] = '{1'b1, 8'hEA, 1'b0, 1'b0,  6'd2,  8'hA9, 1'b0, 2'b00, 1'b0, 1'b0, 11'h401};
        rows[13] = '{1'b1, 8'hEA, 1'b0, 1'b0,  6'd1,  8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 11'h3A0};
        rows[14] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd2,  8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 11'h360};
        rows[15] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd4,  8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 11'h320};
        rows[16] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd8,  8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 11'h5F0};
        rows[17] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd16, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 11'h039};
        rows[18] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd1,  8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000};
        rows[19] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd2,  8'hEA, 1'b0, 2'b00, 1'b0, 1'b0, 11'h001};
        rows[20] = '{1'b1, 8'hFF, 1'b1, 1'b1,  6'd1,  8'hFF, 1'b0, 2'b00, 1'b1, 1'b0, 11'h001};
        rows[21] = '{1'b1, 8'hEA, 1'b1, 1'b1,  6'd1,  8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000};

        // Reset state, before any clock edge is seen as running
        #2;
        chk_state("reset", 6'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 11'h031);
        #10;
        reset_n = 1'b1;

        // NOP flow, LDA imm with a 3-clock stall in C_1
        run_rows(0, 6);
        rdy = 1'b1;
        #1;
        chk("stall release REGW", 32'(x[10]), 32'd1);
        chk("stall release x", 32'(x), 32'h401);
        // IRQ masked, IRQ taken, BRK body, unknown opcode refetch
        run_rows(7, 21);

        // NMI and IRQ pending at the same boundary: NMI first, then IRQ
        nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0; din = 8'hEA;
        tick(2);
        chk_state("nmi E2", 6'd1, 8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000);
        tick(2);
        chk_state("nmi E4", 6'd1, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0, 11'h3A0);
        tick(5);
        chk_state("irq E9", 6'd1, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 11'h3A0);
        irq_n = 1'b1; i_flag = 1'b1; nmi_n = 1'b1;
        tick(5);
        chk_state("plain E14", 6'd1, 8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000);

        // Jam opcode runs off the end of the counter and traps
        tick(1);
        din = 8'h02;
        tick(1);
        chk_state("kil load", 6'd1, 8'h02, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000);
        tick(5);
        chk_state("kil C_5", 6'd32, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0, 11'h000);
        din = 8'hEA;
        tick(1);
        chk_state("trap", 6'd0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 11'h031);
        tick(1);
        chk_state("post trap fetch", 6'd1, 8'hEA, 1'b0, 2'b00, 1'b1, 1'b1, 11'h000);
        tick(1);
        chk_state("trap sticky", 6'd2, 8'hEA, 1'b0, 2'b00, 1'b0, 1'b1, 11'h001);

        // JMP ind with an NMI pending, reset asserted in C_3 without a clock edge
        din = 8'h6C; nmi_n = 1'b0;
        tick(1);
        chk("jmp load ir", 32'(ir_q), 32'h6C);
        tick(3);
        chk_state("jmp C_3", 6'd8, 8'h6C, 1'b0, 2'b00, 1'b0, 1'b1, 11'h5D0);
        #1;
        reset_n = 1'b0;
        #1;
        chk_state("async reset", 6'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 11'h031);
        nmi_n = 1'b1; din = 8'hEA;
        #3;
        reset_n = 1'b1;
        tick(1);
        chk_state("after reset fetch", 6'd1, 8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000);
        tick(2);
        chk_state("nmi discarded", 6'd1, 8'hEA, 1'b0, 2'b00, 1'b1, 1'b0, 11'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
